// File: rtl/vram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vram_pkg : shared widths, types and responder state encoding for VRAM model
// Revision : 1.0
// ----------------------------------------------------------------------------
package vram_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    typedef logic [VRAM_ADDR_W-1:0] vram_addr_t;
    typedef logic [VRAM_DATA_W-1:0] vram_data_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        DRIVE  = 3'd2,
        HOLD   = 3'd3,
        WRITE  = 3'd4
    } vram_resp_state_t;

endpackage
`default_nettype wire

// File: rtl/vram_sram_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vram_sram_array : 2^ADDR_W x DATA_W storage, one write port, two read ports
// Revision        : 1.0
// ----------------------------------------------------------------------------
module vram_sram_array
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_waddr,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic [ADDR_W-1:0] bus_raddr,
    output logic [DATA_W-1:0] bus_rdata,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // Bus commit owns the single write port whenever it is active.
    assign we    = bus_we | dbg_we;
    assign waddr = bus_we ? bus_waddr : dbg_addr;
    assign wdata = bus_we ? bus_wdata : dbg_wdata;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign bus_rdata = mem[bus_raddr];
    assign dbg_rdata = mem[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/vram_sram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vram_sram_responder : clocked pin-level model of the external video SRAM
// Revision            : 1.0
// ----------------------------------------------------------------------------
module vram_sram_responder
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int T_ACC  = 2,
    parameter int T_OH   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ma,
    input  logic [DATA_W-1:0] md_in,
    output logic [DATA_W-1:0] md_out,
    output logic              md_oe,
    input  logic              mcs_n,
    input  logic              moe_n,
    input  logic              mwr_n,
    output logic              wr_commit,
    output logic              bus_conflict,
    output logic              addr_glitch,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam logic [2:0] CNT_ACC = 3'(T_ACC - 1);
    localparam logic [2:0] CNT_OH  = 3'(T_OH);

    logic [ADDR_W-1:0] ma_s, ma_prev;
    logic [DATA_W-1:0] md_s;
    logic              mcs_n_s, moe_n_s, mwr_n_s;
    logic              cs, rd, wr, ma_changed, both_strobes;

    vram_resp_state_t  state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] md_out_nxt;
    logic              md_oe_nxt, conflict_nxt, glitch_nxt, commit, bus_we;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic [DATA_W-1:0] wr_data, wr_data_nxt;
    logic [DATA_W-1:0] mem_rdata, dbg_rdata_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            ma_s      <= '0;
            ma_prev   <= '0;
            md_s      <= '0;
            mcs_n_s   <= 1'b1;
            moe_n_s   <= 1'b1;
            mwr_n_s   <= 1'b1;
            dbg_rdata <= '0;
        end else begin
            ma_s      <= ma;
            ma_prev   <= ma_s;
            md_s      <= md_in;
            mcs_n_s   <= mcs_n;
            moe_n_s   <= moe_n;
            mwr_n_s   <= mwr_n;
            dbg_rdata <= dbg_rdata_raw;
        end
    end

    assign cs           = !mcs_n_s;
    assign rd           = cs & !moe_n_s & mwr_n_s;
    assign wr           = cs & !mwr_n_s;
    assign both_strobes = cs & !moe_n_s & !mwr_n_s;
    assign ma_changed   = (ma_s != ma_prev);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        md_out_nxt   = md_out;
        md_oe_nxt    = md_oe;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        conflict_nxt = bus_conflict | both_strobes | (wr & md_oe);
        glitch_nxt   = addr_glitch;
        commit       = 1'b0;

        if (wr) begin
            wr_addr_nxt = ma_s;
            wr_data_nxt = md_s;
        end

        case (state)
            IDLE: begin
                if (wr) begin
                    state_nxt = WRITE;
                end else if (rd) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = CNT_ACC;
                end
            end
            ACCESS: begin
                if (wr) begin
                    state_nxt = WRITE;
                    md_oe_nxt = 1'b0;
                end else if (!rd) begin
                    if (!md_oe) begin
                        state_nxt = IDLE;
                    end else if (T_OH == 0) begin
                        state_nxt = IDLE;
                        md_oe_nxt = 1'b0;
                    end else begin
                        state_nxt = HOLD;
                        cnt_nxt   = CNT_OH;
                    end
                end else if (ma_changed) begin
                    cnt_nxt = CNT_ACC;
                end else if (cnt == 3'd0) begin
                    md_out_nxt = mem_rdata;
                    md_oe_nxt  = 1'b1;
                    state_nxt  = DRIVE;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            DRIVE: begin
                if (wr) begin
                    state_nxt = WRITE;
                    md_oe_nxt = 1'b0;
                end else if (!rd) begin
                    if (T_OH == 0) begin
                        state_nxt = IDLE;
                        md_oe_nxt = 1'b0;
                    end else begin
                        state_nxt = HOLD;
                        cnt_nxt   = CNT_OH;
                    end
                end else if (ma_changed) begin
                    // Old data stays on MD until the new access completes.
                    state_nxt = ACCESS;
                    cnt_nxt   = CNT_ACC;
                end
            end
            HOLD: begin
                if (wr) begin
                    state_nxt = WRITE;
                    md_oe_nxt = 1'b0;
                end else if (rd) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = CNT_ACC;
                end else if (cnt <= 3'd1) begin
                    state_nxt = IDLE;
                    md_oe_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            WRITE: begin
                md_oe_nxt = 1'b0;
                if (wr) begin
                    if (ma_changed) begin
                        glitch_nxt = 1'b1;
                    end
                end else begin
                    commit = 1'b1;
                    if (rd) begin
                        state_nxt = ACCESS;
                        cnt_nxt   = CNT_ACC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            md_out       <= '0;
            md_oe        <= 1'b0;
            bus_conflict <= 1'b0;
            addr_glitch  <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            md_out       <= md_out_nxt;
            md_oe        <= md_oe_nxt;
            bus_conflict <= conflict_nxt;
            addr_glitch  <= glitch_nxt;
            wr_addr      <= wr_addr_nxt;
            wr_data      <= wr_data_nxt;
        end
    end

    // A commit coinciding with reset is a write in flight and is dropped.
    assign bus_we    = commit & !reset;
    assign wr_commit = bus_we;

    vram_sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk       (clk),
        .bus_we    (bus_we),
        .bus_waddr (wr_addr),
        .bus_wdata (wr_data),
        .bus_raddr (ma_s),
        .bus_rdata (mem_rdata),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata_raw)
    );

endmodule
`default_nettype wire

// File: tb/tb_vram_sram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vram_sram_responder : directed + randomized bench against a memory model
// Revision               : 1.0
// ----------------------------------------------------------------------------
module tb_vram_sram_responder;
    import vram_pkg::*;

    localparam int T_ACC = 2;
    localparam int T_OH  = 1;
    // Pins change at a falling edge; the next rising edge samples them, and the
    // response lands 1 + T_ACC (or 1 + T_OH) rising edges after that sample.
    localparam int RD_TICKS = 1 + (1 + T_ACC);
    localparam int OH_TICKS = 1 + (1 + T_OH);

    logic       clk = 1'b0;
    logic       reset;
    vram_addr_t ma, dbg_addr;
    vram_data_t md_in, md_out, dbg_wdata, dbg_rdata;
    logic       md_oe, mcs_n, moe_n, mwr_n, wr_commit, bus_conflict, addr_glitch, dbg_we;

    vram_data_t model [0:8191];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vram_sram_responder #(.ADDR_W(13), .DATA_W(8), .T_ACC(T_ACC), .T_OH(T_OH)) dut (
        .clk(clk), .reset(reset), .ma(ma), .md_in(md_in), .md_out(md_out), .md_oe(md_oe),
        .mcs_n(mcs_n), .moe_n(moe_n), .mwr_n(mwr_n), .wr_commit(wr_commit),
        .bus_conflict(bus_conflict), .addr_glitch(addr_glitch), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_oe(input logic val, output int lat);
        lat = -1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (md_oe === val) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_commit(output int lat);
        lat = -1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (wr_commit === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic dbg_write(input vram_addr_t a, input vram_data_t d);
        dbg_addr = a; dbg_wdata = d; dbg_we = 1'b1;
        tick();
        dbg_we = 1'b0;
        model[a] = d;
    endtask

    task automatic dbg_check(input vram_addr_t a, input string tag);
        dbg_addr = a;
        tick();
        chk(tag, dbg_rdata, model[a]);
    endtask

    task automatic start_read(input vram_addr_t a, input string tag);
        int lat;
        ma = a; mcs_n = 1'b0; moe_n = 1'b0;
        wait_oe(1'b1, lat);
        chk({tag, "_rd_lat"}, lat, RD_TICKS);
        chk({tag, "_rd_data"}, md_out, model[a]);
    endtask

    task automatic end_read(input bit via_cs, input string tag);
        int lat;
        if (via_cs) mcs_n = 1'b1; else moe_n = 1'b1;
        wait_oe(1'b0, lat);
        chk({tag, "_oh_lat"}, lat, OH_TICKS);
        mcs_n = 1'b1; moe_n = 1'b1;
        tick();
    endtask

    task automatic bus_write(input vram_addr_t a, input vram_data_t d, input int len, input string tag);
        int lat;
        ma = a; md_in = d; mcs_n = 1'b0; mwr_n = 1'b0;
        for (int k = 0; k < len; k++) begin
            tick();
            chk({tag, "_wr_oe"}, md_oe, 0);
            chk({tag, "_wr_early"}, wr_commit, 0);
        end
        mwr_n = 1'b1;
        wait_commit(lat);
        chk({tag, "_commit_lat"}, lat, 1);
        model[a] = d;
        tick();
        chk({tag, "_commit_pulse"}, wr_commit, 0);
        mcs_n = 1'b1;
    endtask

    initial begin
        int lat;
        reset = 1'b1; ma = '0; md_in = '0; mcs_n = 1'b1; moe_n = 1'b1; mwr_n = 1'b1;
        dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) tick();
        chk("rst_oe", md_oe, 0);
        chk("rst_md", md_out, 0);
        chk("rst_commit", wr_commit, 0);
        chk("rst_conflict", bus_conflict, 0);
        chk("rst_glitch", addr_glitch, 0);
        chk("rst_dbg", dbg_rdata, 0);
        reset = 1'b0;
        tick();

        // Plain read with latency and turn-off.
        dbg_write(13'h1A5F, 8'h3C);
        start_read(13'h1A5F, "t1");
        end_read(1'b0, "t1");

        // Plain write observed through the side port.
        bus_write(13'h0800, 8'hA5, 4, "t2");
        dbg_check(13'h0800, "t2_dbg");

        // Address change while driving: old data held, then new data.
        dbg_write(13'h0000, 8'h11);
        dbg_write(13'h0001, 8'h22);
        start_read(13'h0000, "t3");
        ma = 13'h0001;
        for (int k = 1; k <= T_ACC + 2; k++) begin
            tick();
            chk("t3_oe", md_oe, 1);
            chk("t3_md", md_out, (k < T_ACC + 2) ? 8'h11 : 8'h22);
        end

        // Write strobe while driving.
        md_in = 8'h5A; mwr_n = 1'b0;
        tick();
        tick();
        chk("t4_oe_drop", md_oe, 0);
        chk("t4_conflict", bus_conflict, 1);
        mwr_n = 1'b1;
        wait_commit(lat);
        chk("t4_commit_lat", lat, 1);
        model[13'h0001] = 8'h5A;
        wait_oe(1'b1, lat);
        chk("t4_reread_lat", lat, 1 + T_ACC);
        chk("t4_reread_md", md_out, model[13'h0001]);
        end_read(1'b0, "t4");
        chk("t4_sticky", bus_conflict, 1);
        chk("t4_no_glitch", addr_glitch, 0);

        // Address moves during a write.
        dbg_write(13'h0100, 8'h99);
        dbg_write(13'h0101, 8'h00);
        ma = 13'h0100; md_in = 8'h7E; mcs_n = 1'b0; mwr_n = 1'b0;
        tick(); tick();
        ma = 13'h0101;
        tick(); tick();
        chk("t5_glitch", addr_glitch, 1);
        mwr_n = 1'b1;
        wait_commit(lat);
        chk("t5_commit_lat", lat, 1);
        model[13'h0101] = 8'h7E;
        tick();
        mcs_n = 1'b1;
        dbg_check(13'h0101, "t5_new");
        dbg_check(13'h0100, "t5_old");

        // Bus commit and side-port write to the same address in one cycle.
        dbg_write(13'h0200, 8'h01);
        ma = 13'h0200; md_in = 8'hB4; mcs_n = 1'b0; mwr_n = 1'b0;
        tick(); tick();
        mwr_n = 1'b1;
        wait_commit(lat);
        chk("t6c_commit_lat", lat, 1);
        dbg_addr = 13'h0200; dbg_wdata = 8'h4B; dbg_we = 1'b1;
        tick();
        dbg_we = 1'b0; mcs_n = 1'b1;
        model[13'h0200] = 8'hB4;
        tick();
        dbg_check(13'h0200, "t6c_bus_wins");

        // Reset in the middle of a write discards it.
        dbg_write(13'h0300, 8'h12);
        ma = 13'h0300; md_in = 8'hC7; mcs_n = 1'b0; mwr_n = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("t6_oe", md_oe, 0);
        chk("t6_md", md_out, 0);
        chk("t6_commit", wr_commit, 0);
        chk("t6_conflict", bus_conflict, 0);
        chk("t6_glitch", addr_glitch, 0);
        chk("t6_dbg", dbg_rdata, 0);
        mwr_n = 1'b1; mcs_n = 1'b1;
        tick();
        chk("t6_commit_rst", wr_commit, 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_commit_after", wr_commit, 0);
        end
        dbg_check(13'h0300, "t6_mem");

        // Randomized transactions over a preloaded window.
        for (int a = 0; a < 64; a++) dbg_write(13'(a), 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            vram_addr_t ra;
            ra = 13'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0: begin
                    start_read(ra, "rnd");
                    repeat ($urandom_range(0, 3)) begin
                        tick();
                        chk("rnd_hold", md_out, model[ra]);
                    end
                    end_read(bit'($urandom_range(0, 1)), "rnd");
                end
                1: begin
                    bus_write(ra, 8'($urandom), int'($urandom_range(1, 4)), "rnd");
                    tick();
                end
                2: dbg_write(ra, 8'($urandom));
                default: dbg_check(ra, "rnd_dbg");
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
